fetch_pipe: RTL

FETCH_PIPE -- requirements
Module: fetch_pipe

---
 rtl/fetch_pipe.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch_pipe.sv
// Instruction fetch pipeline: PC generator, one-deep request
// tracking and a small in-order queue feeding decode.
module fetch_pipe #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 4,
  parameter int          PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  logic              i_halt,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [DATA_W-1:0] i_imem_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_instr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc_r;
  logic              infl;
  logic [ADDR_W-1:0] infl_pc;
  logic [CW-1:0]     count;
  logic [CW-1:0]     occ;
  logic [PW-1:0]     head, tail;
  logic [ADDR_W-1:0] q_pc  [DEPTH];
  logic [DATA_W-1:0] q_ins [DEPTH];
  logic              push, pop;

  // Request gating counts the in-flight slot so a push never overflows.
  always_comb begin
    occ        = count + {{(CW-1){1'b0}}, infl};
    o_imem_req = (state == S_RUN) && !i_redirect
               && (occ < CW'(DEPTH));
    push       = infl && !i_redirect;
    pop        = o_valid && i_ready && !i_redirect;
  end

  assign o_imem_addr = pc_r;
  assign o_valid     = (count != '0);
  assign o_pc        = q_pc[head];
  assign o_instr     = q_ins[head];

  // Next-state logic; redirect never affects the FSM.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_BOOT:  state_nx = S_RUN;
      S_RUN:   if (i_halt)  state_nx = S_HALT;
      S_HALT:  if (!i_halt) state_nx = S_RUN;
      default: state_nx = S_BOOT;
    endcase
  end

  // Control state: FSM, PC, in-flight tracking, queue pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_BOOT;
      pc_r    <= RESET_PC;
      infl    <= 1'b0;
      infl_pc <= '0;
      count   <= '0;
      head    <= '0;
      tail    <= '0;
    end else begin
      state <= state_nx;
      infl  <= o_imem_req;
      if (o_imem_req) begin
        pc_r    <= pc_r + ADDR_W'(PC_STEP);
        infl_pc <= pc_r;
      end
      if (i_redirect) begin
        pc_r  <= i_redirect_pc;
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  // Queue storage needs no reset; count qualifies every entry.
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_pc[tail]  <= infl_pc;
      q_ins[tail] <= i_imem_data;
    end
  end

endmodule
